// File: rtl/seq_serializer_if.sv
// Handshake and serial-line bundle between a word source and seq_serializer.
// The serializer takes the slave side; the word source takes the master side.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_ready;
  logic             o_seq;
  logic             o_seq_valid;
  logic             o_last;
  logic [CW-1:0]    o_bit_cnt;

  modport master (
    output i_data, i_valid,
    input  o_ready, o_seq, o_seq_valid, o_last, o_bit_cnt
  );

  modport slave (
    input  i_data, i_valid,
    output o_ready, o_seq, o_seq_valid, o_last, o_bit_cnt
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detector: one bit per clock,
// back-to-back words stream with no gap, and the line rests at IDLE_LEVEL.
module seq_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  seq_serializer_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_next;
  logic [WIDTH-1:0] shreg_q, shreg_next;
  logic             seq_q, seq_next;
  logic             seq_valid_q, seq_valid_next;
  logic             last_q, last_next;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_next;
  logic             at_last;
  logic             accept;

  // Ready also on the final bit of a word, so the next word loads with no gap.
  assign at_last     = (state_q == SHIFT) && (bit_cnt_q == LAST_IDX);
  assign bus.o_ready = reset && ((state_q == IDLE) || at_last);
  assign accept      = bus.i_valid && bus.o_ready;

  assign bus.o_seq       = seq_q;
  assign bus.o_seq_valid = seq_valid_q;
  assign bus.o_last      = last_q;
  assign bus.o_bit_cnt   = bit_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      seq_q       <= IDLE_LEVEL;
      seq_valid_q <= 1'b0;
      last_q      <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_next;
      shreg_q     <= shreg_next;
      seq_q       <= seq_next;
      seq_valid_q <= seq_valid_next;
      last_q      <= last_next;
      bit_cnt_q   <= bit_cnt_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (at_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first bit goes straight to the line on load; the shift register keeps
  // only the bits still to come, so its outgoing end is always the next bit.
  always_comb begin
    shreg_next     = shreg_q;
    seq_next       = IDLE_LEVEL;
    seq_valid_next = 1'b0;
    bit_cnt_next   = '0;
    if (accept) begin
      seq_valid_next = 1'b1;
      if (MSB_FIRST) begin
        seq_next   = bus.i_data[WIDTH-1];
        shreg_next = bus.i_data << 1;
      end else begin
        seq_next   = bus.i_data[0];
        shreg_next = bus.i_data >> 1;
      end
    end else if ((state_q == SHIFT) && !at_last) begin
      seq_valid_next = 1'b1;
      bit_cnt_next   = bit_cnt_q + CW'(1);
      if (MSB_FIRST) begin
        seq_next   = shreg_q[WIDTH-1];
        shreg_next = shreg_q << 1;
      end else begin
        seq_next   = shreg_q[0];
        shreg_next = shreg_q >> 1;
      end
    end
    last_next = seq_valid_next && (bit_cnt_next == LAST_IDX);
  end
endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: MSB-first and LSB-first instances share one stimulus
// and are checked every cycle against a bit-queue model, plus literal sequences.
module tb_seq_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] tb_data;
  logic         tb_valid;

  always #5 clk = ~clk;

  seq_serializer_if #(.WIDTH(W)) bus_msb ();
  seq_serializer_if #(.WIDTH(W)) bus_lsb ();

  assign bus_msb.i_data  = tb_data;
  assign bus_msb.i_valid = tb_valid;
  assign bus_lsb.i_data  = tb_data;
  assign bus_lsb.i_valid = tb_valid;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .bus(bus_msb)
  );
  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .bus(bus_lsb)
  );

  typedef struct {
    bit b_msb;
    bit b_lsb;
    int idx;
  } exp_t;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  bit   check_en     = 1'b0;
  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid    = 1'b0;
  bit   exp_ready;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [W-1:0] d);
    tb_valid = v;
    tb_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLine(input string tag, input logic rdy, input logic sv,
                           input logic s, input logic lst, input logic [2:0] cnt,
                           input bit exp_bit);
    checkOutput({tag, ".ready"}, rdy, exp_ready);
    checkOutput({tag, ".seq_valid"}, sv, cur_valid);
    checkOutput({tag, ".seq"}, s, cur_valid ? exp_bit : 1'b1);
    checkOutput({tag, ".last"}, lst, cur_valid && (cur.idx == W - 1));
    if (cur_valid) checkOutput({tag, ".bit_cnt"}, cnt, cur.idx);
  endtask

  // Model: an accepted word becomes W queued line bits; each clock the line
  // shows the next queued bit, or idles when the queue is empty.
  task automatic modelStep();
    if (!reset) begin
      exp_q.delete();
      cur_valid = 1'b0;
    end else begin
      if (tb_valid && exp_ready) begin
        for (int k = 0; k < W; k++) begin
          exp_t e;
          e.b_msb = tb_data[W-1-k];
          e.b_lsb = tb_data[k];
          e.idx   = k;
          exp_q.push_back(e);
        end
      end
      if (exp_q.size() > 0) begin
        cur       = exp_q.pop_front();
        cur_valid = 1'b1;
      end else begin
        cur_valid = 1'b0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      exp_ready = reset && (!cur_valid || (cur.idx == W - 1));
      if (check_en) begin
        checkLine("msb", bus_msb.o_ready, bus_msb.o_seq_valid, bus_msb.o_seq,
                  bus_msb.o_last, bus_msb.o_bit_cnt, cur.b_msb);
        checkLine("lsb", bus_lsb.o_ready, bus_lsb.o_seq_valid, bus_lsb.o_seq,
                  bus_lsb.o_last, bus_lsb.o_bit_cnt, cur.b_lsb);
      end
      modelStep();
    end
  end

  // Sequences are written first-bit-leftmost for each instance.
  task automatic runWord(input string tag, input logic [W-1:0] seq_m,
                         input logic [W-1:0] seq_l);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput({tag, ".m_seq"}, bus_msb.o_seq, seq_m[W-1-i]);
      checkOutput({tag, ".l_seq"}, bus_lsb.o_seq, seq_l[W-1-i]);
      checkOutput({tag, ".valid"}, bus_msb.o_seq_valid, 1'b1);
      checkOutput({tag, ".last"}, bus_msb.o_last, i == W - 1);
      checkOutput({tag, ".cnt"}, bus_msb.o_bit_cnt, i);
      checkOutput({tag, ".ready"}, bus_lsb.o_ready, i == W - 1);
      tick();
    end
  endtask

  task automatic idleCheck(input string tag);
    @(negedge clk);
    checkOutput({tag, ".idle_seq"}, bus_msb.o_seq, 1'b1);
    checkOutput({tag, ".idle_valid"}, bus_lsb.o_seq_valid, 1'b0);
    checkOutput({tag, ".idle_last"}, bus_msb.o_last, 1'b0);
    checkOutput({tag, ".idle_ready"}, bus_msb.o_ready, 1'b1);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    tick();
    check_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst.seq", bus_msb.o_seq, 1'b1);
      checkOutput("rst.valid", bus_msb.o_seq_valid, 1'b0);
      checkOutput("rst.last", bus_lsb.o_last, 1'b0);
      checkOutput("rst.cnt", bus_msb.o_bit_cnt, 0);
      checkOutput("rst.ready", bus_msb.o_ready, 1'b0);
    end
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, '0);
    idleCheck("start");

    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, '0);
    runWord("a5", 8'hA5, 8'hA5);
    idleCheck("a5");

    applyStimulus(1'b1, 8'h01);
    tick();
    applyStimulus(1'b0, '0);
    runWord("w01", 8'h01, 8'h80);
    idleCheck("w01");

    applyStimulus(1'b1, 8'hFF);
    tick();
    applyStimulus(1'b1, 8'h00);
    runWord("b2b_ff", 8'hFF, 8'hFF);
    applyStimulus(1'b0, '0);
    runWord("b2b_00", 8'h00, 8'h00);
    idleCheck("b2b");

    applyStimulus(1'b1, 8'h0F);
    tick();
    applyStimulus(1'b1, 8'h55);
    runWord("bp_0f", 8'h0F, 8'hF0);
    applyStimulus(1'b0, '0);
    runWord("bp_55", 8'h55, 8'hAA);
    idleCheck("bp");

    applyStimulus(1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("mid.cnt", bus_msb.o_bit_cnt, i);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid.cnt3", bus_msb.o_bit_cnt, 3);
    checkOutput("mid.ready_rst", bus_msb.o_ready, 1'b0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid.after_seq", bus_msb.o_seq, 1'b1);
    checkOutput("mid.after_valid", bus_msb.o_seq_valid, 1'b0);
    checkOutput("mid.after_cnt", bus_lsb.o_bit_cnt, 0);
    tick();
    applyStimulus(1'b1, 8'h00);
    tick();
    applyStimulus(1'b0, '0);
    runWord("fresh", 8'h00, 8'h00);
    idleCheck("fresh");

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, W'($urandom));
      reset = ($urandom_range(0, 59) != 0);
      tick();
    end
    reset = 1'b1;
    applyStimulus(1'b0, '0);
    repeat (W + 2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
